speed_mode_ctrl: RTL
====================

SPEED_MODE_CTRL -- requirements
Module: speed_mode_ctrl

Interface
REQ-001 SHALL have parameter DIV_SLOW, default 100_000_000, counter-tick period in clk cycles for SLOW mode (1 Hz at 100 MHz).
REQ-002 SHALL have parameter DIV_MED, default 1_000_000, counter-tick period for MED mode (100 Hz).
REQ-003 SHALL have parameter DIV_FAST, default 100, counter-tick period for FAST mode (1 MHz).
REQ-004 SHALL have parameter DBN_SLOW, default 1_000_000, debounce-tick period in SLOW mode (100 Hz).
REQ-005 SHALL have parameter DBN_MED, default 10_000, debounce-tick period in MED mode (10 kHz).
REQ-006 SHALL have parameter DBN_FAST, default 1, debounce-tick period in FAST mode (every cycle).
REQ-007 SHALL have port clk  input  1  single system clock (100 MHz); all logic in this one domain.
REQ-008 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-009 SHALL have port btn_mode  input  1  debounced, synchronous level; rising edge cycles speed mode.
REQ-010 SHALL have port btn_start  input  1  debounced level; rising edge toggles run/pause.
REQ-011 SHALL have port btn_clear  input  1  debounced level; rising edge returns to idle.
REQ-012 SHALL have port mode  output  2  current speed mode: 00 SLOW, 01 MED, 10 FAST.
REQ-013 SHALL have port switch_clk  output  1  mode code bit: 1 only in MED.
REQ-014 SHALL have port switch_clk1  output  1  mode code bit: 1 only in FAST.
REQ-015 SHALL have port run  output  1  high while in RUN state.
REQ-016 SHALL have port tick_counter  output  1  one-cycle counter enable pulse.
REQ-017 SHALL have port tick_debounce  output  1  one-cycle debounce-sample enable pulse.
REQ-018 SHALL have port clear_pulse  output  1  one-cycle pulse on entry to IDLE via btn_clear.

Function
REQ-019 SHALL detect a rising edge as input==1 while its registered previous value==0; the resulting action takes effect at that same clk edge (outputs visible the following cycle).
REQ-020 SHALL cycle mode SLOW->MED->FAST->SLOW on each btn_mode edge; code 11 is unreachable and, if ever present, SHALL be treated as SLOW on the next edge.
REQ-021 SHALL implement control FSM IDLE/RUN/PAUSE: btn_start edge IDLE->RUN, RUN->PAUSE, PAUSE->RUN; btn_clear edge any state->IDLE.
REQ-022 SHALL give btn_clear priority over btn_start in the same cycle (result IDLE, no RUN entry).
REQ-023 SHALL apply a btn_mode edge in any FSM state, including the cycle of a simultaneous start or clear edge.
REQ-024 SHALL keep a counter-divider that increments only in RUN, holds in PAUSE, is zero in IDLE, and wraps to 0 at (period-1) for the current mode.
REQ-025 SHALL assert tick_counter for exactly one cycle when the counter-divider wraps while in RUN; never in IDLE or PAUSE.
REQ-026 SHALL keep a free-running debounce-divider (all states) wrapping at (DBN period-1) and pulsing tick_debounce on wrap; DBN period 1 SHALL give tick_debounce constantly high.
REQ-027 SHALL zero both dividers on a mode change, so the first tick in the new mode arrives one full new period later.
REQ-028 SHALL size divider registers to hold the largest period parameter minus one; no truncation at defaults.
REQ-029 SHALL register all outputs; no combinational path from buttons to outputs.

Reset
REQ-030 SHALL, while rst is high, force mode=00, switch_clk=0, switch_clk1=0, FSM=IDLE, run=0, all ticks and clear_pulse=0, both dividers=0.
REQ-031 SHALL reset edge-detector history registers to 1, so a button held through reset release produces no action until released and re-pressed.
REQ-032 SHALL, on rst asserted mid-RUN, abandon the current period immediately; after release the FSM is IDLE and SLOW.

Verification (sim params DIV_SLOW=10, DIV_MED=6, DIV_FAST=3, DBN_SLOW=4, DBN_MED=2, DBN_FAST=1)
REQ-033 Reset release, start edge -> run=1 next cycle; tick_counter pulses every 10 cycles, first pulse 10 cycles after RUN entry.
REQ-034 Three btn_mode edges -> mode 01 (switch_clk=1), 10 (switch_clk1=1), 00; tick spacing 6, 3, 10; tick_debounce spacing 2, 1 (constant high), 4.
REQ-035 RUN for 4 cycles, start edge (PAUSE) for 20 cycles, start edge -> no ticks during PAUSE; next tick 6 cycles after resume.
REQ-036 btn_start and btn_clear rising same cycle while RUN -> IDLE, run=0, clear_pulse one cycle, no tick_counter afterward.
REQ-037 btn_start held high across rst release -> FSM stays IDLE; release then re-press -> RUN.
REQ-038 rst asserted asynchronously mid-period (between clk edges) -> outputs reach reset values without waiting for clk.

Source files
------------

// File: rtl/speed_mode_ctrl_if.sv
// Button inputs and registered status/tick outputs of the speed-mode controller.
interface speed_mode_ctrl_if;
  logic       btn_mode;
  logic       btn_start;
  logic       btn_clear;
  logic [1:0] mode;
  logic       switch_clk;
  logic       switch_clk1;
  logic       run;
  logic       tick_counter;
  logic       tick_debounce;
  logic       clear_pulse;

  modport master (
    output btn_mode, btn_start, btn_clear,
    input  mode, switch_clk, switch_clk1, run, tick_counter, tick_debounce, clear_pulse
  );

  modport slave (
    input  btn_mode, btn_start, btn_clear,
    output mode, switch_clk, switch_clk1, run, tick_counter, tick_debounce, clear_pulse
  );
endinterface

// File: rtl/speed_mode_ctrl.sv
// Speed-mode selector with IDLE/RUN/PAUSE control FSM, a run-gated counter
// divider and a free-running debounce divider; periods follow the current mode.
module speed_mode_ctrl #(
  parameter int unsigned DIV_SLOW = 100_000_000,
  parameter int unsigned DIV_MED  = 1_000_000,
  parameter int unsigned DIV_FAST = 100,
  parameter int unsigned DBN_SLOW = 1_000_000,
  parameter int unsigned DBN_MED  = 10_000,
  parameter int unsigned DBN_FAST = 1
) (
  input  logic              clk,
  input  logic              rst,
  speed_mode_ctrl_if.slave  bus
);

  localparam int unsigned DIV_MAX_SM = (DIV_SLOW > DIV_MED) ? DIV_SLOW : DIV_MED;
  localparam int unsigned DIV_MAX    = (DIV_MAX_SM > DIV_FAST) ? DIV_MAX_SM : DIV_FAST;
  localparam int unsigned DBN_MAX_SM = (DBN_SLOW > DBN_MED) ? DBN_SLOW : DBN_MED;
  localparam int unsigned DBN_MAX    = (DBN_MAX_SM > DBN_FAST) ? DBN_MAX_SM : DBN_FAST;
  localparam int unsigned CNT_W      = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int unsigned DBN_W      = (DBN_MAX > 1) ? $clog2(DBN_MAX) : 1;

  localparam logic [1:0] MODE_SLOW = 2'b00;
  localparam logic [1:0] MODE_MED  = 2'b01;
  localparam logic [1:0] MODE_FAST = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         mode_q, mode_d;
  logic               switch_clk_q, switch_clk_d;
  logic               switch_clk1_q, switch_clk1_d;
  logic               run_q, run_d;
  logic               tick_counter_q, tick_counter_d;
  logic               tick_debounce_q, tick_debounce_d;
  logic               clear_pulse_q, clear_pulse_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [DBN_W-1:0]   dbn_q, dbn_d;
  logic               mode_prev_q, mode_prev_d;
  logic               start_prev_q, start_prev_d;
  logic               clear_prev_q, clear_prev_d;

  logic               mode_edge, start_edge, clear_edge;
  logic [CNT_W-1:0]   cnt_last;
  logic [DBN_W-1:0]   dbn_last;

  // Rising edges against the previous sampled level
  always_comb begin
    mode_edge  = bus.btn_mode  & ~mode_prev_q;
    start_edge = bus.btn_start & ~start_prev_q;
    clear_edge = bus.btn_clear & ~clear_prev_q;
  end

  // Terminal counts for the mode currently in force
  always_comb begin
    cnt_last = CNT_W'(DIV_SLOW - 1);
    dbn_last = DBN_W'(DBN_SLOW - 1);
    case (mode_q)
      MODE_MED: begin
        cnt_last = CNT_W'(DIV_MED - 1);
        dbn_last = DBN_W'(DBN_MED - 1);
      end
      MODE_FAST: begin
        cnt_last = CNT_W'(DIV_FAST - 1);
        dbn_last = DBN_W'(DBN_FAST - 1);
      end
      default: ;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    mode_d          = mode_q;
    cnt_d           = cnt_q;
    dbn_d           = dbn_q;
    tick_counter_d  = 1'b0;
    tick_debounce_d = 1'b0;
    clear_pulse_d   = 1'b0;
    mode_prev_d     = bus.btn_mode;
    start_prev_d    = bus.btn_start;
    clear_prev_d    = bus.btn_clear;

    if (clear_edge) begin
      state_d       = ST_IDLE;
      clear_pulse_d = 1'b1;
    end else if (start_edge) begin
      case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        default:  state_d = ST_IDLE;
      endcase
    end

    // Code 11 is interpreted as SLOW, so its next step is MED
    if (mode_edge) begin
      case (mode_q)
        MODE_MED:  mode_d = MODE_FAST;
        MODE_FAST: mode_d = MODE_SLOW;
        default:   mode_d = MODE_MED;
      endcase
    end

    if (mode_edge || clear_edge) begin
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      if (cnt_q >= cnt_last) begin
        cnt_d          = '0;
        tick_counter_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    // A mode change restarts the debounce period from zero
    if (mode_edge) begin
      dbn_d = '0;
    end else if (dbn_q >= dbn_last) begin
      dbn_d           = '0;
      tick_debounce_d = 1'b1;
    end else begin
      dbn_d = dbn_q + DBN_W'(1);
    end

    switch_clk_d  = (mode_d == MODE_MED);
    switch_clk1_d = (mode_d == MODE_FAST);
    run_d         = (state_d == ST_RUN);
  end

  // State and output registers; edge history resets high so held buttons are ignored
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      mode_q          <= MODE_SLOW;
      switch_clk_q    <= 1'b0;
      switch_clk1_q   <= 1'b0;
      run_q           <= 1'b0;
      tick_counter_q  <= 1'b0;
      tick_debounce_q <= 1'b0;
      clear_pulse_q   <= 1'b0;
      cnt_q           <= '0;
      dbn_q           <= '0;
      mode_prev_q     <= 1'b1;
      start_prev_q    <= 1'b1;
      clear_prev_q    <= 1'b1;
    end else begin
      state_q         <= state_d;
      mode_q          <= mode_d;
      switch_clk_q    <= switch_clk_d;
      switch_clk1_q   <= switch_clk1_d;
      run_q           <= run_d;
      tick_counter_q  <= tick_counter_d;
      tick_debounce_q <= tick_debounce_d;
      clear_pulse_q   <= clear_pulse_d;
      cnt_q           <= cnt_d;
      dbn_q           <= dbn_d;
      mode_prev_q     <= mode_prev_d;
      start_prev_q    <= start_prev_d;
      clear_prev_q    <= clear_prev_d;
    end
  end

  assign bus.mode          = mode_q;
  assign bus.switch_clk    = switch_clk_q;
  assign bus.switch_clk1   = switch_clk1_q;
  assign bus.run           = run_q;
  assign bus.tick_counter  = tick_counter_q;
  assign bus.tick_debounce = tick_debounce_q;
  assign bus.clear_pulse   = clear_pulse_q;

endmodule
